// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM type and constants for prio_arbiter and prio_pick
package arb_pkg;
    typedef enum logic {IDLE, GRANT} state_t;
    localparam int ARB_MODE_FIXED = 0;
    localparam int ARB_MODE_RR = 1;
    localparam int STAT_W = 16;
    localparam int STARVE_MULT = 4;
endpackage

// File: rtl/prio_pick.sv
// prio_pick: combinational pick of one set bit of req & mask, fixed or round-robin order
// Ports: req/mask candidate vectors, base = last winner (round-robin anchor),
// rr_mode selects round-robin; onehot/idx/any describe the winner (zero when none).
module prio_pick #(
    parameter int N = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] base,
    input  logic             rr_mode,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [N-1:0] v;
    // k-th index to try: fixed scans down from N-1, round-robin scans down from base-1 with wrap
    function automatic logic [IDX_W-1:0] pos(input int k, input logic [IDX_W-1:0] b, input logic m);
        return IDX_W'(m ? (int'(b) + 2 * N - 1 - k) % N : N - 1 - k);
    endfunction
    always_comb begin
        v = req & mask;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && v[pos(k, base, rr_mode)]) begin
                any = 1'b1;
                idx = pos(k, base, rr_mode);
            end
        end
        onehot = '0;
        onehot[idx] = any;
    end
endmodule

// File: rtl/prio_arbiter.sv
// prio_arbiter: registered N-way arbiter with grant locking, optional round-robin and hold limit
// Ports: clk, rst (sync, active-high), req[N] requests, gnt[N] registered one-hot grant,
// gnt_valid = |gnt, gnt_idx binary index of the owner (0 when idle).
// With PRIO_ARBITER_STATS_EN defined: grant_count (saturating new-grant count) and
// starve (sticky, any requester waited more than STARVE_MULT*N cycles).
module prio_arbiter import arb_pkg::*; #(
    parameter int N = 4,
    parameter int RR_MODE = 0,
    parameter int MAX_HOLD = 0,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
`ifdef PRIO_ARBITER_STATS_EN
    ,
    output logic [STAT_W-1:0] grant_count,
    output logic              starve
`endif
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1) + 1;
    state_t state_q, state_d;
    logic [N-1:0] gnt_q, gnt_d, pick_mask, pick_oh;
    logic [IDX_W-1:0] idx_q, idx_d, rr_q, rr_d, pick_idx;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic pick_any, own, expire, new_g;
    assign own = (state_q == GRANT) && |(req & gnt_q);
    assign expire = (MAX_HOLD > 0) && (hold_q == HOLD_W'(MAX_HOLD));
    // on expiry the current owner is excluded so someone else gets a turn
    assign pick_mask = (own && expire) ? ~gnt_q : '1;
    prio_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
        .req(req),
        .mask(pick_mask),
        .base(rr_q),
        .rr_mode(RR_MODE == ARB_MODE_RR),
        .onehot(pick_oh),
        .idx(pick_idx),
        .any(pick_any)
    );
    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        idx_d = idx_q;
        hold_d = hold_q;
        rr_d = rr_q;
        new_g = 1'b0;
        if (own && !expire) begin
            hold_d = (MAX_HOLD > 0) ? hold_q + 1'b1 : hold_q;
        end else if (pick_any) begin
            state_d = GRANT;
            gnt_d = pick_oh;
            idx_d = pick_idx;
            hold_d = HOLD_W'(1);
            rr_d = pick_idx;
            new_g = 1'b1;
        end else if (own) begin
            hold_d = HOLD_W'(1);
            new_g = 1'b1;
        end else begin
            state_d = IDLE;
            gnt_d = '0;
            idx_d = '0;
            hold_d = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q <= '0;
            idx_q <= '0;
            hold_q <= '0;
            rr_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            idx_q <= idx_d;
            hold_q <= hold_d;
            rr_q <= rr_d;
        end
    end
    assign gnt = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_idx = idx_q;
`ifdef PRIO_ARBITER_STATS_EN
    localparam int WAIT_W = $clog2(STARVE_MULT * N) + 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_MULT * N + 1);
    logic [STAT_W-1:0] cnt_q;
    logic [N-1:0][WAIT_W-1:0] wait_q, wait_d;
    logic starve_q, starve_d;
    // wait counters saturate one past the limit, so reaching WAIT_MAX means "waited too long"
    always_comb begin
        starve_d = starve_q;
        for (int i = 0; i < N; i++) begin
            wait_d[i] = (req[i] && !gnt_q[i]) ? ((wait_q[i] == WAIT_MAX) ? WAIT_MAX : wait_q[i] + 1'b1) : '0;
            starve_d = starve_d | (wait_d[i] == WAIT_MAX);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            wait_q <= '0;
            starve_q <= 1'b0;
        end else begin
            cnt_q <= (new_g && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
            wait_q <= wait_d;
            starve_q <= starve_d;
        end
    end
    assign grant_count = cnt_q;
    assign starve = starve_q;
`else
    logic unused_new_g;
    assign unused_new_g = new_g;
`endif
endmodule

// File: tb/tb_prio_arbiter.sv
// tb_prio_arbiter: scoreboard bench for fixed, round-robin and hold-limited arbiters
module tb_prio_arbiter;
    typedef struct {
        int          cyc;
        int          d;
        logic [3:0]  g;
        logic        st;
        logic        sv;
        logic [15:0] gc;
        string       nm;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req_v [3];
    logic [3:0] gnt_v [3];
    logic [1:0] idx_v [3];
    logic val_v [3];
`ifdef PRIO_ARBITER_STATS_EN
    logic [15:0] gc_v [3];
    logic sv_v [3];
`endif
    exp_t sb[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    prio_arbiter #(.N(4), .RR_MODE(0), .MAX_HOLD(0)) u_fix (
        .clk(clk), .rst(rst), .req(req_v[0]), .gnt(gnt_v[0]), .gnt_valid(val_v[0]), .gnt_idx(idx_v[0])
`ifdef PRIO_ARBITER_STATS_EN
        , .grant_count(gc_v[0]), .starve(sv_v[0])
`endif
    );
    prio_arbiter #(.N(4), .RR_MODE(1), .MAX_HOLD(0)) u_rr (
        .clk(clk), .rst(rst), .req(req_v[1]), .gnt(gnt_v[1]), .gnt_valid(val_v[1]), .gnt_idx(idx_v[1])
`ifdef PRIO_ARBITER_STATS_EN
        , .grant_count(gc_v[1]), .starve(sv_v[1])
`endif
    );
    prio_arbiter #(.N(4), .RR_MODE(0), .MAX_HOLD(3)) u_hold (
        .clk(clk), .rst(rst), .req(req_v[2]), .gnt(gnt_v[2]), .gnt_valid(val_v[2]), .gnt_idx(idx_v[2])
`ifdef PRIO_ARBITER_STATS_EN
        , .grant_count(gc_v[2]), .starve(sv_v[2])
`endif
    );
    function automatic logic [1:0] idx_of(input logic [3:0] g);
        return g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
    endfunction
    task automatic put(input int d, input logic [3:0] r, input logic [3:0] g, input string nm,
                       input logic st = 1'b0, input logic sv = 1'b0, input logic [15:0] gc = 16'd0);
        req_v[d] = r;
        sb.push_back('{cyc + 1, d, g, st, sv, gc, nm});
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ({gnt_v[e.d], idx_v[e.d], val_v[e.d]} !== {e.g, idx_of(e.g), |e.g}) begin
                    errors++;
                    $display("FAIL %s dut%0d cyc%0d: gnt=%b idx=%0d valid=%b, want gnt=%b idx=%0d valid=%b",
                             e.nm, e.d, cyc, gnt_v[e.d], idx_v[e.d], val_v[e.d], e.g, idx_of(e.g), |e.g);
                end
`ifdef PRIO_ARBITER_STATS_EN
                if (e.st) begin
                    checks++;
                    if ({gc_v[e.d], sv_v[e.d]} !== {e.gc, e.sv}) begin
                        errors++;
                        $display("FAIL %s_stats dut%0d cyc%0d: grant_count=%0d starve=%b, want grant_count=%0d starve=%b",
                                 e.nm, e.d, cyc, gc_v[e.d], sv_v[e.d], e.gc, e.sv);
                    end
                end
`endif
            end
        end
    end
    initial begin
        foreach (req_v[i]) req_v[i] = 4'b0000;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) put(d, 4'b0000, 4'b0000, "reset", d == 0);
        tick();
        rst = 1'b0;
        put(0, 4'b0111, 4'b0100, "fix_first");
        tick();
        repeat (10) begin
            put(0, 4'b0111, 4'b0100, "fix_hold");
            tick();
        end
        put(0, 4'b1100, 4'b0100, "no_preempt");
        tick();
        put(0, 4'b0011, 4'b0010, "fix_handoff");
        tick();
        put(0, 4'b0000, 4'b0000, "fix_idle");
        tick();
        put(0, 4'b0001, 4'b0001, "fix_low");
        tick();
        put(0, 4'b0000, 4'b0000, "fix_idle2");
        tick();
        put(1, 4'b1111, 4'b1000, "rr_3");
        tick();
        put(1, 4'b0111, 4'b0100, "rr_2");
        tick();
        put(1, 4'b1011, 4'b0010, "rr_1");
        tick();
        put(1, 4'b1101, 4'b0001, "rr_0");
        tick();
        put(1, 4'b1110, 4'b1000, "rr_wrap3");
        tick();
        put(1, 4'b1110, 4'b1000, "rr_keep");
        tick();
        repeat (3) begin
            put(2, 4'b1001, 4'b1000, "hold_a");
            tick();
        end
        repeat (3) begin
            put(2, 4'b1001, 4'b0001, "hold_b");
            tick();
        end
        put(2, 4'b1001, 4'b1000, "hold_a2");
        tick();
        repeat (6) begin
            put(2, 4'b1000, 4'b1000, "hold_solo");
            tick();
        end
        put(2, 4'b0000, 4'b0000, "hold_idle");
        tick();
        put(0, 4'b0111, 4'b0100, "pre_rst");
        put(1, 4'b1110, 4'b1000, "pre_rst");
        tick();
        rst = 1'b1;
        put(0, 4'b0111, 4'b0000, "rst_mid", 1'b1);
        put(1, 4'b1110, 4'b0000, "rst_mid");
        put(2, 4'b0000, 4'b0000, "rst_mid");
        tick();
        rst = 1'b0;
        put(0, 4'b0111, 4'b0100, "post_rst");
        put(1, 4'b1111, 4'b1000, "rr_restart");
        tick();
        put(0, 4'b0000, 4'b0000, "post_idle");
        put(1, 4'b0111, 4'b0100, "rr_next");
        tick();
        put(1, 4'b0000, 4'b0000, "rr_idle");
        tick();
        rst = 1'b1;
        put(0, 4'b0000, 4'b0000, "stat_rst", 1'b1);
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            put(0, 4'b1001, 4'b1000, "stat", 1'b1, k >= 17, 16'd1);
            tick();
        end
        put(0, 4'b0000, 4'b0000, "end");
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prio_arbiter.md
Name: prio_arbiter

Overview:
Parametrised N-way request arbiter. It generalises the team's combinational highest-index-wins priority encoder into a registered, stateful arbiter.
Adds a selectable round-robin mode, grant locking while the owner keeps requesting, and a bounded hold time for fairness.
Sits in front of shared resources (bus, memory port); its one-hot grant drives the downstream mux select.

Parameters:
N, 4, number of requesters (2..32).
RR_MODE, 0, 0 = fixed priority (highest index wins); 1 = round-robin.
MAX_HOLD, 0, maximum consecutive grant cycles per owner; 0 = unlimited.
IDX_W, $clog2(N), width of gnt_idx (derived, not overridden).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req  input  N  request vector; bit i = requester i.
gnt  output  N  registered one-hot grant; all zero when idle.
gnt_valid  output  1  high when gnt is nonzero.
gnt_idx  output  IDX_W  binary index of the granted requester; 0 when idle.

Behaviour:
- Interface decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - gnt=0, gnt_valid=0, gnt_idx=0.
  - FSM=IDLE, hold_cnt=0.
  - rr_last=0, so the first round-robin search starts at index N-1.
- Reset mid-grant: gnt drops to 0 in the cycle after rst is sampled high. No residual state survives reset.
- Pick function, pick(v):
  - Fixed mode: highest set index of v.
  - RR mode: search downward from rr_last-1, wrapping to N-1, ending at rr_last. The first set bit wins.
  - v==0 gives no winner.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req!=0: register gnt=onehot(pick(req)), load hold_cnt=1, go to GRANT.
  - Latency is 1 cycle from req to gnt.
  - Otherwise stay in IDLE.
- GRANT, owner o:
  - Keep (req[o]=1, and MAX_HOLD=0 or hold_cnt<MAX_HOLD): gnt unchanged; hold_cnt increments, saturating at MAX_HOLD.
  - Release (req[o]=0): next gnt=pick(req). Back-to-back handoff with no bubble. If req==0, go to IDLE with gnt=0.
  - Expiry (req[o]=1 and hold_cnt==MAX_HOLD, MAX_HOLD>0): next gnt=pick(req & ~onehot(o)). If no other requester, re-grant o and reload hold_cnt=1.
  - Any new grant loads hold_cnt=1.
- rr_last updates to the winning index on every new grant, in both modes; it is used only when RR_MODE=1.
- Requests arriving while another requester is locked are ignored until release or expiry. No preemption, even by higher priority.
- Invariants:
  - gnt is always 0 or one-hot.
  - gnt_idx is consistent with gnt.
  - gnt_valid == |gnt.
- A requester must hold req until granted. Dropping req before grant is legal; the request is simply lost.

Optional Feature:
Macro: PRIO_ARBITER_STATS_EN.
- Defined:
  - Adds output grant_count[15:0], a saturating count of new grants. Holds at 16'hFFFF once reached.
  - Adds output starve, a sticky flag set when any requester has req high for more than 4*N consecutive cycles without being granted.
  - Both clear only on rst.
  - Costs one 16-bit counter and N wait counters of width clog2(4N)+1.
- Undefined: neither port nor its logic exists. Core behaviour is identical with or without the macro.

Decomposition:
- Package arb_pkg holds:
  - FSM state typedef: IDLE, GRANT.
  - Localparams ARB_MODE_FIXED=0 and ARB_MODE_RR=1.
  - Stats counter width constant (16).
  - The starvation multiplier (4).
- Sub-module prio_pick: purely combinational (req, mask, base, rr_mode) -> (onehot, idx, any).
  - Instantiated once in prio_arbiter.
  - Unit-testable standalone against the fixed-priority encoder truth table.
- prio_arbiter holds the FSM, hold counter, rr_last and output registers.

Test Plan:
- Fixed, N=4, MAX_HOLD=0: req=4'b0111 from IDLE -> one cycle later gnt=4'b0100, gnt_idx=2; gnt held for 10 cycles while req[2]=1.
- Fixed handoff: owner 2; req goes 0111->0011 -> next cycle gnt=0010, no idle cycle. Then req=0000 -> gnt=0000, gnt_valid=0.
- RR, N=4: req=4'b1111 held steady with each owner dropping req for one cycle after grant -> grant order 3,2,1,0,3.
- MAX_HOLD=3, fixed: req=1001 held -> gnt=1000 for 3 cycles, gnt=0001 for 3 cycles, then 1000. With req=1000 only -> gnt=1000 continuous.
- Reset mid-grant: gnt=0100, rst=1 for one cycle -> next edge gnt=0, gnt_idx=0. RR restarts from index 3 after reset.
- Stats (PRIO_ARBITER_STATS_EN, MAX_HOLD=0): req=1001 held 20 cycles -> starve=1 after cycle 17, grant_count=1.
